cache_stage2_ctrl: RTL
======================

Name: cache_stage2_ctrl

Overview:
- Parametrised second pipeline stage of the set-associative data cache.
- Compares the registered stage-one request against per-way tag/valid/dirty/data read from the arrays, serves hits, and updates tree-PLRU.
- Owns a registered miss FSM for dirty writeback, line fill, install and replay.
- Generalises the 4-way combinational hit logic to N ways, with an explicit write-hit bubble and invalid-way-first victim selection.

Parameters:
NUM_WAYS, 4, associativity; power of two, ≥2
LINE_BYTES, 32, line size in bytes; LINE_BITS = 8*LINE_BYTES, OFF_W = log2(LINE_BYTES)
INDEX_W, 4, set index width
TAG_W, 23, tag width; TAG_W+INDEX_W+OFF_W must equal 32 (elaboration-time assert)

Ports:
clk  in  1  clock
rst_n  in  1  async active-low reset
req_valid  in  1  registered stage-one request present
req_tag  in  TAG_W  request tag
req_index  in  INDEX_W  request set
req_offset  in  OFF_W  byte offset, word-aligned
req_rmask  in  4  read byte mask
req_wmask  in  4  write byte mask
req_wdata  in  32  write data
req_ready  out  1  stage can advance; 0 = stall stage one
way_data  in  NUM_WAYS*LINE_BITS  array lines for req_index
way_tag  in  NUM_WAYS*TAG_W  array tags
way_valid  in  NUM_WAYS  valid bits
way_dirty  in  NUM_WAYS  dirty bits
plru_rd  in  NUM_WAYS-1  PLRU bits for req_index
plru_wr  out  NUM_WAYS-1  new PLRU bits
plru_we  out  1  PLRU write enable
arr_we  out  NUM_WAYS  one-hot array write enable
arr_wdata  out  LINE_BITS  line to write
arr_wtag  out  TAG_W  tag to write (valid set implicitly)
arr_wdirty  out  1  dirty bit to write
ufp_resp  out  1  request complete
ufp_rdata  out  32  read data, bytes outside rmask zeroed
dfp_addr  out  32  line-aligned memory address
dfp_read  out  1  line read request
dfp_write  out  1  line write request
dfp_wdata  out  LINE_BITS  writeback line
dfp_rdata  in  LINE_BITS  fill line
dfp_resp  in  1  memory completion

Behaviour:
- Reset: the FSM goes to IDLE, the victim/fill registers clear, and every strobe output is 0. req_ready=1 while in IDLE with no pending action.
- A request is active when req_valid=1 and rmask|wmask≠0. Otherwise there is no action: req_ready=1, and no PLRU or array write occurs.
- Hit: some way has way_valid=1 and a matching tag. Multiple matches are illegal and the lowest index wins.
- Read hit, IDLE: ufp_resp=1 in the same cycle. ufp_rdata = word at req_offset, masked by rmask. plru_we=1. req_ready=1.
- Write hit, IDLE: same-cycle ufp_resp=1. arr_we[hit]=1. arr_wdata = hit line with wmask bytes merged at req_offset. arr_wdirty=1. plru_we=1. req_ready=0. Next state is BUBBLE.
- BUBBLE: one cycle with no action and req_ready=1, then IDLE. This guarantees a following access to the same set sees the written line.
- PLRU is a tree. Node i has children 2i+1 and 2i+2; bit=0 means the victim lies in the left (lower-way) subtree. On access, each node on the path is set to point away from the accessed way. PLRU is updated only on hits, including replay hits.
- Miss in IDLE:
  - Victim = lowest-index invalid way, else the PLRU walk. Victim index is latched.
  - req_ready=0 until the replay hit.
  - If the victim is valid and dirty, go to WB; otherwise go to FILL.
- WB: dfp_write=1, dfp_addr={victim tag, index, 0}, dfp_wdata=victim line. These are held stable until dfp_resp, then go to FILL.
- FILL: dfp_read=1, dfp_addr={req_tag, req_index, 0}, held until dfp_resp. Capture dfp_rdata, then go to INSTALL.
- INSTALL: arr_we[victim]=1, arr_wdata=fill line, arr_wtag=req_tag, arr_wdirty=0. Next is IDLE, where the held request is re-looked-up and hits.
- Latency:
  - Read hit: 0 cycles after the request.
  - Clean miss: fill latency + 2 cycles.
  - Dirty miss: adds writeback latency.
- Invariants:
  - dfp_read and dfp_write are never both 1.
  - dfp_resp outside WB/FILL is ignored.
  - Request inputs must stay stable while req_ready=0.
- Reset mid-miss: strobes drop asynchronously and the FSM returns to IDLE. The abandoned memory transaction is discarded by the memory side.

Optional Feature:
- CACHE_PERF_CNT_EN defined: adds outputs perf_hits, perf_misses and perf_writebacks, each 32 bits. They are saturating counters that increment on the first-lookup hit, on miss entry, and on WB completion. Replay hits are not counted. All three reset to 0.
- Macro undefined: ports and counters are absent. Behaviour is otherwise identical.

Test Plan:
- Read hit way 2, offset 8, rmask 4'b0011, line word=0xDEADBEEF -> same-cycle ufp_resp=1, rdata=0x0000BEEF, plru_wr path toward way 2 flipped away, req_ready=1.
- Write hit way 0, wmask 4'b1000, wdata 0xAA000000 -> ufp_resp=1, arr_we=4'b0001, only byte 3 of the word changed, arr_wdirty=1, req_ready=0 for exactly 1 cycle.
- Clean miss with way 1 invalid, memory resp after 5 cycles -> dfp_read held 5 cycles at {tag,index,5'b0}, INSTALL arr_we=4'b0010, replay ufp_resp at cycle 7.
- Dirty miss, all valid, plru_rd=3'b000 -> victim way 0, dfp_write with victim address and line until resp, then dfp_read, install, replay hit.
- rst_n low during FILL -> dfp_read=0 immediately, FSM in IDLE, later request handled normally.
- With CACHE_PERF_CNT_EN: 3 hits, 1 dirty miss -> perf_hits=3, perf_misses=1, perf_writebacks=1.

Source files
------------

// File: rtl/cache_stage2_ctrl.sv
// Data cache stage two: N-way hit/PLRU logic and registered miss FSM.
// Optional perf counters enabled with CACHE_PERF_CNT_EN.
module cache_stage2_ctrl #(
  parameter int NUM_WAYS   = 4,
  parameter int LINE_BYTES = 32,
  parameter int INDEX_W    = 4,
  parameter int TAG_W      = 23,
  localparam int LINE_BITS = 8 * LINE_BYTES,
  localparam int OFF_W     = $clog2(LINE_BYTES),
  localparam int WAY_W     = $clog2(NUM_WAYS)
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          req_valid,
  input  logic [TAG_W-1:0]              req_tag,
  input  logic [INDEX_W-1:0]            req_index,
  input  logic [OFF_W-1:0]              req_offset,
  input  logic [3:0]                    req_rmask,
  input  logic [3:0]                    req_wmask,
  input  logic [31:0]                   req_wdata,
  output logic                          req_ready,
  input  logic [NUM_WAYS*LINE_BITS-1:0] way_data,
  input  logic [NUM_WAYS*TAG_W-1:0]     way_tag,
  input  logic [NUM_WAYS-1:0]           way_valid,
  input  logic [NUM_WAYS-1:0]           way_dirty,
  input  logic [NUM_WAYS-2:0]           plru_rd,
  output logic [NUM_WAYS-2:0]           plru_wr,
  output logic                          plru_we,
  output logic [NUM_WAYS-1:0]           arr_we,
  output logic [LINE_BITS-1:0]          arr_wdata,
  output logic [TAG_W-1:0]              arr_wtag,
  output logic                          arr_wdirty,
  output logic                          ufp_resp,
  output logic [31:0]                   ufp_rdata,
  output logic [31:0]                   dfp_addr,
  output logic                          dfp_read,
  output logic                          dfp_write,
  output logic [LINE_BITS-1:0]          dfp_wdata,
  input  logic [LINE_BITS-1:0]          dfp_rdata,
  input  logic                          dfp_resp
`ifdef CACHE_PERF_CNT_EN
  ,
  output logic [31:0]                   perf_hits,
  output logic [31:0]                   perf_misses,
  output logic [31:0]                   perf_writebacks
`endif
);

  localparam int WORDS = LINE_BYTES / 4;

  if (TAG_W + INDEX_W + OFF_W != 32) begin : g_bad_addr
    $error("TAG_W + INDEX_W + OFF_W must equal 32");
  end
  if (NUM_WAYS < 2 || (1 << WAY_W) != NUM_WAYS) begin : g_bad_ways
    $error("NUM_WAYS must be a power of two >= 2");
  end

  typedef enum logic [2:0] {
    S_IDLE, S_BUBBLE, S_WB, S_FILL, S_INSTALL
  } state_t;

  state_t state_q, state_d;
  logic [WAY_W-1:0]     victim_q;
  logic [LINE_BITS-1:0] fill_q;

  logic [LINE_BITS-1:0] lines [NUM_WAYS];
  logic [TAG_W-1:0]     tags  [NUM_WAYS];

  for (genvar g = 0; g < NUM_WAYS; g++) begin : g_split
    assign lines[g] = way_data[g*LINE_BITS +: LINE_BITS];
    assign tags[g]  = way_tag[g*TAG_W +: TAG_W];
  end

  logic                 active, hit, inv_any;
  logic                 latch_victim, fill_en;
  logic [WAY_W-1:0]     hit_way, inv_way;
  logic [WAY_W-1:0]     plru_vict, victim_d;
  logic [NUM_WAYS-2:0]  plru_upd;
  logic [LINE_BITS-1:0] hit_line, merged;
  logic [31:0]          hit_word, rdata;
  logic [OFF_W-3:0]     word_sel;
  logic                 unused_bits;

  assign unused_bits = ^req_offset[1:0];
  assign active   = req_valid && ((req_rmask | req_wmask) != 4'b0);
  assign word_sel = req_offset[OFF_W-1:2];
  assign hit_line = lines[hit_way];
  assign victim_d = inv_any ? inv_way : plru_vict;

  // Descending scans so the lowest matching index wins.
  always_comb begin
    hit     = 1'b0;
    hit_way = '0;
    inv_any = 1'b0;
    inv_way = '0;
    for (int w = NUM_WAYS - 1; w >= 0; w--) begin
      if (way_valid[w] && tags[w] == req_tag) begin
        hit     = 1'b1;
        hit_way = WAY_W'(w);
      end
      if (!way_valid[w]) begin
        inv_any = 1'b1;
        inv_way = WAY_W'(w);
      end
    end
  end

  always_comb begin
    int node;
    node      = 0;
    plru_vict = '0;
    for (int l = 0; l < WAY_W; l++) begin
      plru_vict[WAY_W-1-l] = plru_rd[node];
      node = 2 * node + 1 + int'(plru_rd[node]);
    end
  end

  always_comb begin
    int node;
    logic dir;
    node     = 0;
    plru_upd = plru_rd;
    for (int l = 0; l < WAY_W; l++) begin
      dir            = hit_way[WAY_W-1-l];
      plru_upd[node] = ~dir;
      node = 2 * node + 1 + int'(dir);
    end
  end

  always_comb begin
    hit_word = '0;
    merged   = hit_line;
    for (int k = 0; k < WORDS; k++) begin
      if (int'(word_sel) == k) begin
        hit_word = hit_line[k*32 +: 32];
        for (int b = 0; b < 4; b++)
          if (req_wmask[b])
            merged[k*32+8*b +: 8] = req_wdata[8*b +: 8];
      end
    end
    for (int b = 0; b < 4; b++)
      rdata[8*b +: 8] = req_rmask[b] ? hit_word[8*b +: 8] : 8'h00;
  end

  always_comb begin
    state_d      = state_q;
    req_ready    = 1'b0;
    ufp_resp     = 1'b0;
    ufp_rdata    = '0;
    plru_we      = 1'b0;
    plru_wr      = plru_rd;
    arr_we       = '0;
    arr_wdata    = '0;
    arr_wtag     = req_tag;
    arr_wdirty   = 1'b0;
    dfp_addr     = '0;
    dfp_read     = 1'b0;
    dfp_write    = 1'b0;
    dfp_wdata    = '0;
    latch_victim = 1'b0;
    fill_en      = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (!active) begin
          req_ready = 1'b1;
        end else if (hit) begin
          ufp_resp  = 1'b1;
          ufp_rdata = rdata;
          plru_we   = 1'b1;
          plru_wr   = plru_upd;
          if (|req_wmask) begin
            arr_we[hit_way] = 1'b1;
            arr_wdata       = merged;
            arr_wdirty      = 1'b1;
            state_d         = S_BUBBLE;
          end else begin
            req_ready = 1'b1;
          end
        end else begin
          latch_victim = 1'b1;
          state_d = (way_valid[victim_d] && way_dirty[victim_d])
                  ? S_WB : S_FILL;
        end
      end
      S_BUBBLE: begin
        req_ready = 1'b1;
        state_d   = S_IDLE;
      end
      S_WB: begin
        dfp_write = 1'b1;
        dfp_addr  = {tags[victim_q], req_index, {OFF_W{1'b0}}};
        dfp_wdata = lines[victim_q];
        if (dfp_resp) state_d = S_FILL;
      end
      S_FILL: begin
        dfp_read = 1'b1;
        dfp_addr = {req_tag, req_index, {OFF_W{1'b0}}};
        if (dfp_resp) begin
          fill_en = 1'b1;
          state_d = S_INSTALL;
        end
      end
      S_INSTALL: begin
        arr_we[victim_q] = 1'b1;
        arr_wdata        = fill_q;
        state_d          = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      victim_q <= '0;
      fill_q   <= '0;
    end else begin
      state_q <= state_d;
      if (latch_victim) victim_q <= victim_d;
      if (fill_en) fill_q <= dfp_rdata;
    end
  end

`ifdef CACHE_PERF_CNT_EN
  logic replay_q;
  logic hit_evt, miss_evt, wb_evt;

  assign hit_evt  = state_q == S_IDLE && active && hit && !replay_q;
  assign miss_evt = state_q == S_IDLE && active && !hit;
  assign wb_evt   = state_q == S_WB && dfp_resp;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      replay_q        <= 1'b0;
      perf_hits       <= '0;
      perf_misses     <= '0;
      perf_writebacks <= '0;
    end else begin
      replay_q <= state_q == S_INSTALL;
      if (hit_evt && !(&perf_hits))
        perf_hits <= perf_hits + 32'd1;
      if (miss_evt && !(&perf_misses))
        perf_misses <= perf_misses + 32'd1;
      if (wb_evt && !(&perf_writebacks))
        perf_writebacks <= perf_writebacks + 32'd1;
    end
  end
`endif

endmodule
